// File: rtl/count_seq_ctrl_if.sv
// Bundle of host-side and counter-side signals for count_seq_ctrl.
// master: host/counter model side (drives start/stop/pause/mode/tc/cnt_q).
// slave:  the sequencer (drives cnt_en/cnt_clr/busy/done/runs).
interface count_seq_ctrl_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic             stop;
  logic             pause;
  logic             mode;
  logic [WIDTH-1:0] tc;
  logic [WIDTH-1:0] cnt_q;
  logic             cnt_en;
  logic             cnt_clr;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] runs;

  modport master (
    output start, stop, pause, mode, tc, cnt_q,
    input  cnt_en, cnt_clr, busy, done, runs
  );

  modport slave (
    input  start, stop, pause, mode, tc, cnt_q,
    output cnt_en, cnt_clr, busy, done, runs
  );
endinterface

// File: rtl/count_seq_ctrl.sv
// Sequencer for a WIDTH-bit up-counter: clears it, enables it up to tc, pulses done.
// Ports: clk, rst (async active-low), bus (slave modport: start/stop/pause/mode/tc/cnt_q in;
//        cnt_en/cnt_clr/busy/done/runs out). One-shot or auto-reload; stop > pause > start.
module count_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  count_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tc_r;
  logic             mode_r;
  logic [WIDTH-1:0] runs_r;
  logic             done_r;
  logic             at_tc;
  logic             cnt_en_c;
  logic             cnt_clr_c;

  assign at_tc = (bus.cnt_q == tc_r);

  always_comb begin
    state_nxt = state;
    cnt_en_c  = 1'b0;
    cnt_clr_c = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start && !bus.stop) state_nxt = CLEAR;
      end
      CLEAR: begin
        cnt_clr_c = !bus.stop;
        state_nxt = bus.stop ? IDLE : RUN;
      end
      RUN: begin
        // pause only gates the enable; reaching tc still ends the run
        cnt_en_c = !bus.stop && !bus.pause && !at_tc;
        if (bus.stop)   state_nxt = IDLE;
        else if (at_tc) state_nxt = DONE;
      end
      DONE: begin
        // a stop landing on DONE keeps this pulse but cancels the reload
        state_nxt = (mode_r && !bus.stop) ? CLEAR : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      tc_r   <= '0;
      mode_r <= 1'b0;
      runs_r <= '0;
      done_r <= 1'b0;
    end else begin
      state  <= state_nxt;
      // done is registered so it is high exactly while the FSM sits in DONE
      done_r <= (state_nxt == DONE);
      if (state == IDLE && bus.start && !bus.stop) begin
        tc_r   <= bus.tc;
        mode_r <= bus.mode;
        runs_r <= '0;
      end else if (state == DONE) begin
        runs_r <= runs_r + 1'b1;
      end
    end
  end

  assign bus.cnt_en  = cnt_en_c;
  assign bus.cnt_clr = cnt_clr_c;
  assign bus.busy    = (state != IDLE);
  assign bus.done    = done_r;
  assign bus.runs    = runs_r;

endmodule
